// File: rtl/unstripe_sched_if.sv
// unstripe_sched_if: striped lane inputs and serialised output stream of the unstripe path
interface unstripe_sched_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0] lane0;
    logic              valid0;
    logic [DATA_W-1:0] lane1;
    logic              valid1;
    logic              out_ready;
    logic [DATA_W-1:0] dataOut;
    logic              validOut;
    modport master (output lane0, valid0, lane1, valid1, out_ready, input dataOut, validOut);
    modport slave (input lane0, valid0, lane1, valid1, out_ready, output dataOut, validOut);
endinterface

// File: rtl/unstripe_sched.sv
// unstripe_sched: round-robin re-serialiser of two striped lanes with alignment, backpressure and sticky error detection
module unstripe_sched #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 4,
    parameter int SKEW_MAX = 2
) (
    input  logic            clk_2f,
    input  logic            reset,
    input  logic            resync,
    unstripe_sched_if.slave bus,
    output logic            overflow0,
    output logic            overflow1,
    output logic            err_skew,
    output logic            busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(SKEW_MAX + 2) + 1;
    localparam logic signed [SW-1:0] ONE = SW'(1);
    localparam logic signed [SW-1:0] ZERO = SW'(0);
    localparam logic signed [SW-1:0] SMAX = SW'(SKEW_MAX);
    localparam logic signed [SW-1:0] SSAT = SW'(SKEW_MAX + 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, ERROR} state_t;
    state_t state, state_nx;
    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];
    logic [AW-1:0] wp0, rp0, wp1, rp1;
    logic [AW:0] cnt0, cnt1;
    logic ptr;
    logic signed [SW-1:0] skew, skew_sum, skew_nx;
    logic req0, req1, pop, pop0, pop1, drop0, drop1, wr0, wr1, skew_bad;
    always_comb begin
        req0 = state != ERROR && bus.valid0;
        req1 = (state == RUN && bus.valid1) || (state == IDLE && bus.valid0 && bus.valid1);
        pop = state == RUN && (ptr ? cnt1 != '0 : cnt0 != '0) && (!bus.validOut || bus.out_ready);
        pop0 = pop && !ptr;
        pop1 = pop && ptr;
        drop0 = req0 && cnt0 == FULL && !pop0;
        drop1 = req1 && cnt1 == FULL && !pop1;
        wr0 = req0 && !drop0;
        wr1 = req1 && !drop1;
        skew_sum = skew + (req0 ? ONE : ZERO) - (req1 ? ONE : ZERO);
        skew_bad = state != ERROR && (skew_sum > SMAX || skew_sum < -SMAX);
        skew_nx = skew_sum > SMAX ? SSAT : skew_sum < -SMAX ? -SSAT : skew_sum;
        state_nx = resync ? IDLE
                 : (state == ERROR || drop0 || drop1 || skew_bad) ? ERROR
                 : req0 ? RUN : state;
    end
    always_ff @(posedge clk_2f or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk_2f) begin
        if (wr0) mem0[wp0] <= bus.lane0;
        if (wr1) mem1[wp1] <= bus.lane1;
    end
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            {wp0, rp0, wp1, rp1, cnt0, cnt1, ptr} <= '0;
            skew <= ZERO;
            bus.dataOut <= '0;
            bus.validOut <= 1'b0;
            {overflow0, overflow1, err_skew} <= '0;
        end else if (resync) begin
            {wp0, rp0, wp1, rp1, cnt0, cnt1, ptr} <= '0;
            skew <= ZERO;
            bus.dataOut <= '0;
            bus.validOut <= 1'b0;
            {overflow0, overflow1, err_skew} <= '0;
        end else begin
            wp0 <= wp0 + AW'(wr0);
            wp1 <= wp1 + AW'(wr1);
            rp0 <= rp0 + AW'(pop0);
            rp1 <= rp1 + AW'(pop1);
            cnt0 <= cnt0 + (AW + 1)'(wr0) - (AW + 1)'(pop0);
            cnt1 <= cnt1 + (AW + 1)'(wr1) - (AW + 1)'(pop1);
            ptr <= ptr ^ pop;
            skew <= skew_nx;
            overflow0 <= overflow0 | drop0;
            overflow1 <= overflow1 | drop1;
            err_skew <= err_skew | skew_bad;
            if (pop) begin
                bus.dataOut <= ptr ? mem1[rp1] : mem0[rp0];
                bus.validOut <= 1'b1;
            end else if (state != RUN || bus.out_ready) begin
                bus.validOut <= 1'b0;
            end
        end
    end
    assign busy = state == RUN;
endmodule

// File: tb/tb_unstripe_sched.sv
// tb_unstripe_sched: scoreboard bench for the unstripe sequencer
module tb_unstripe_sched;
    logic clk_2f = 1'b0;
    logic reset = 1'b1;
    logic resync = 1'b0;
    logic overflow0, overflow1, err_skew, busy;
    logic [31:0] exp_q[$];
    int total = 0;
    int bad = 0;
    unstripe_sched_if #(.DATA_W(32)) bus();
    unstripe_sched #(.DATA_W(32), .DEPTH(4), .SKEW_MAX(2)) dut (
        .clk_2f(clk_2f),
        .reset(reset),
        .resync(resync),
        .bus(bus),
        .overflow0(overflow0),
        .overflow1(overflow1),
        .err_skew(err_skew),
        .busy(busy)
    );
    always #5 clk_2f = ~clk_2f;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge clk_2f);
        #2;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask
    task automatic idle_in();
        bus.valid0 = 1'b0;
        bus.valid1 = 1'b0;
    endtask
    task automatic drain();
        idle_in();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
        check("drain", 32'(exp_q.size()), 32'd0);
        tick();
    endtask
    task automatic check_flags(input string tag);
        check({tag, "_flags"}, {29'd0, overflow0, overflow1, err_skew}, 32'd0);
    endtask
    // Alternating lanes, one word per lane every other cycle
    task automatic run_seq(input string tag, input int n);
        bus.out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.valid0 = 1'b1;
            bus.valid1 = 1'b0;
            bus.lane0 = 32'hFFFF_FFFF - 32'(2 * i);
            exp_q.push_back(bus.lane0);
            tick();
            if (i == 0) check({tag, "_lat0"}, bus.validOut, 1'b0);
            bus.valid0 = 1'b0;
            bus.valid1 = 1'b1;
            bus.lane1 = 32'hFFFF_FFFE - 32'(2 * i);
            exp_q.push_back(bus.lane1);
            tick();
            if (i == 0) check({tag, "_lat1"}, bus.validOut, 1'b1);
        end
        drain();
        check_flags(tag);
    endtask
    always @(negedge clk_2f) begin
        logic [31:0] e;
        if (bus.validOut && bus.out_ready) begin
            e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
            check("out_word", bus.dataOut, e);
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
    initial begin
        idle_in();
        bus.lane0 = '0;
        bus.lane1 = '0;
        bus.out_ready = 1'b1;
        do_reset();
        check("rst_valid", bus.validOut, 1'b0);
        check("rst_data", bus.dataOut, 32'd0);
        check("rst_busy", busy, 1'b0);
        check_flags("rst");
        run_seq("s1", 4);
        do_reset();
        bus.valid1 = 1'b1;
        bus.lane1 = 32'h0000_AAAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s2_idle", busy, 1'b0);
        end
        bus.valid0 = 1'b1;
        bus.lane0 = 32'h1;
        bus.lane1 = 32'h2;
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h2);
        tick();
        check("s2_busy", busy, 1'b1);
        drain();
        check_flags("s2");
        do_reset();
        bus.valid0 = 1'b1;
        bus.lane0 = 32'h100;
        tick();
        idle_in();
        bus.out_ready = 1'b0;
        tick();
        check("s3_first_v", bus.validOut, 1'b1);
        check("s3_first_d", bus.dataOut, 32'h100);
        for (int i = 0; i < 5; i++) begin
            bus.valid0 = 1'b1;
            bus.valid1 = 1'b1;
            bus.lane0 = 32'h200 + 32'(i);
            bus.lane1 = 32'h300 + 32'(i);
            tick();
            check("s3_hold", bus.dataOut, 32'h100);
            check("s3_ovf0", overflow0, i == 4);
            check("s3_ovf1", overflow1, i == 4);
        end
        idle_in();
        check("s3_vhold", bus.validOut, 1'b1);
        tick();
        check("s3_verr", bus.validOut, 1'b0);
        check("s3_busy", busy, 1'b0);
        check("s3_dhold", bus.dataOut, 32'h100);
        check("s3_skew", err_skew, 1'b0);
        bus.out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.valid0 = 1'b1;
            bus.lane0 = 32'h400 + 32'(i);
            if (i == 0) exp_q.push_back(bus.lane0);
            tick();
            check("s4_skew", err_skew, i == 2);
            bus.valid0 = 1'b0;
            tick();
        end
        check("s4_busy", busy, 1'b0);
        check("s4_ovf", {overflow0, overflow1}, 2'b00);
        check("s4_valid", bus.validOut, 1'b0);
        check("s4_drain", 32'(exp_q.size()), 32'd0);
        resync = 1'b1;
        tick();
        resync = 1'b0;
        check_flags("s5");
        check("s5_valid", bus.validOut, 1'b0);
        check("s5_busy", busy, 1'b0);
        run_seq("s5", 4);
        bus.valid0 = 1'b1;
        bus.valid1 = 1'b1;
        bus.lane0 = 32'h500;
        bus.lane1 = 32'h501;
        tick();
        idle_in();
        bus.out_ready = 1'b0;
        tick();
        check("s6_pre", bus.validOut, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("s6_async_v", bus.validOut, 1'b0);
        check("s6_async_d", bus.dataOut, 32'd0);
        check("s6_async_b", busy, 1'b0);
        tick();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s6_stale", bus.validOut, 1'b0);
        end
        run_seq("s6", 4);
        check("final_q", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
